// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
//  Module   : aes_key_expand
//  Purpose  : Iterative AES-128 key schedule. Accepts one 128-bit cipher key
//             and presents round keys 0..10 in order, one per accepted beat,
//             computing the next round key in a single clock.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                 in    1   clock, all state on rising edge
//    resetn              in    1   asynchronous active-low reset
//    key_valid_in        in    1   key_in is valid this cycle
//    key_in              in  128   cipher key, w0 = [127:96] .. w3 = [31:0]
//    key_ready_out       out   1   block can accept a new key
//    rk_valid_out        out   1   rk_out / rk_round_out valid
//    rk_ready_in         in    1   consumer accepts the current round key
//    rk_round_out        out   4   round index of rk_out, 0..10
//    rk_out              out 128   round key, same word ordering as key_in
//    busy_out            out   1   expansion in progress
//    last_key_valid_out  out   1   (AES_KEY_LAST_OUT_EN) last_key_out valid
//    last_key_out        out 128   (AES_KEY_LAST_OUT_EN) round-10 key
//
//  Build option: define AES_KEY_LAST_OUT_EN to add a capture register holding
//  the round-10 key (the decrypt start key) after each completed expansion.
// ============================================================================
module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         key_valid_in,
    input  logic [127:0] key_in,
    output logic         key_ready_out,
    output logic         rk_valid_out,
    input  logic         rk_ready_in,
    output logic [3:0]   rk_round_out,
    output logic [127:0] rk_out,
`ifdef AES_KEY_LAST_OUT_EN
    output logic         last_key_valid_out,
    output logic [127:0] last_key_out,
`endif
    output logic         busy_out
);

    // FIPS-197 forward S-box; entry 0x00 sits in the most significant byte.
    localparam logic [2047:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [3:0] C_LAST_ROUND = NR[3:0];

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [127:0]  rk_q, rk_d;
    logic [3:0]    round_q, round_d;
`ifdef AES_KEY_LAST_OUT_EN
    logic          last_valid_q, last_valid_d;
    logic [127:0]  last_key_q, last_key_d;
`endif

    // ~b == 255-b, so {~b,3'b000} is the bit offset of entry b in C_SBOX.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return C_SBOX[{~b, 3'b000} +: 8];
    endfunction

    // Rcon for the round being produced, i.e. round_q + 1.
    logic [7:0]   w_rcon;
    logic [31:0]  w_rot;
    logic [31:0]  w_t;
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [127:0] w_next;

    always_comb begin
        w_rcon = 8'h00;
        case (round_q)
            4'd0:    w_rcon = 8'h01;
            4'd1:    w_rcon = 8'h02;
            4'd2:    w_rcon = 8'h04;
            4'd3:    w_rcon = 8'h08;
            4'd4:    w_rcon = 8'h10;
            4'd5:    w_rcon = 8'h20;
            4'd6:    w_rcon = 8'h40;
            4'd7:    w_rcon = 8'h80;
            4'd8:    w_rcon = 8'h1b;
            4'd9:    w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    always_comb begin
        w_rot  = {rk_q[23:0], rk_q[31:24]};
        w_t    = {sbox(w_rot[31:24]) ^ w_rcon, sbox(w_rot[23:16]),
                  sbox(w_rot[15:8]), sbox(w_rot[7:0])};
        w_w0   = rk_q[127:96] ^ w_t;
        w_w1   = rk_q[95:64]  ^ w_w0;
        w_w2   = rk_q[63:32]  ^ w_w1;
        w_w3   = rk_q[31:0]   ^ w_w2;
        w_next = {w_w0, w_w1, w_w2, w_w3};
    end

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
`ifdef AES_KEY_LAST_OUT_EN
        last_valid_d = last_valid_q;
        last_key_d   = last_key_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (key_valid_in) begin
                    rk_d    = key_in;
                    round_d = 4'd0;
                    state_d = ST_EXPAND;
`ifdef AES_KEY_LAST_OUT_EN
                    last_valid_d = 1'b0;
`endif
                end
            end
            ST_EXPAND: begin
                // key_valid_in is deliberately ignored while expanding.
                if (rk_ready_in) begin
                    if (round_q == C_LAST_ROUND) begin
                        // rk_out keeps the final key; only the valid drops.
                        state_d = ST_IDLE;
`ifdef AES_KEY_LAST_OUT_EN
                        last_valid_d = 1'b1;
                        last_key_d   = rk_q;
`endif
                    end else begin
                        rk_d    = w_next;
                        round_d = round_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            rk_q    <= '0;
            round_q <= '0;
`ifdef AES_KEY_LAST_OUT_EN
            last_valid_q <= 1'b0;
            last_key_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
`ifdef AES_KEY_LAST_OUT_EN
            last_valid_q <= last_valid_d;
            last_key_q   <= last_key_d;
`endif
        end
    end

    assign key_ready_out = (state_q == ST_IDLE);
    assign rk_valid_out  = (state_q == ST_EXPAND);
    assign busy_out      = (state_q == ST_EXPAND);
    assign rk_round_out  = round_q;
    assign rk_out        = rk_q;
`ifdef AES_KEY_LAST_OUT_EN
    assign last_key_valid_out = last_valid_q;
    assign last_key_out       = last_key_q;
`endif

endmodule
`default_nettype wire

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule sitting directly upstream of the aes round datapath.
- Accepts one 128-bit cipher key and emits the 11 round keys (round 0..10) in order, one per accepted output beat.
- The aes core consumes one beat per round via a valid/ready handshake.
- One round-key computation per clock: 4 S-box lookups, RotWord and Rcon XOR.

Parameters:
- NR, 10, index of the last round; fixed for AES-128; only value supported.

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- key_valid_in  in  1  key_in is valid this cycle
- key_in  in  128  cipher key; word w0 = key_in[127:96], w3 = key_in[31:0]
- key_ready_out  out  1  block can accept a new key
- rk_valid_out  out  1  rk_out / rk_round_out valid
- rk_ready_in  in  1  consumer accepts the current round key
- rk_round_out  out  4  round index of rk_out, 0..10
- rk_out  out  128  round key, same word ordering as key_in
- busy_out  out  1  expansion in progress (state EXPAND)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, resetn).
- Reset values: state=IDLE; key_ready_out=1; rk_valid_out=0; rk_round_out=0; rk_out=0; busy_out=0.
- States: IDLE and EXPAND.
- IDLE:
  - key_ready_out=1; rk_valid_out=0.
  - On key_valid_in=1: latch key_in into rk_out, set rk_round_out=0 and go to EXPAND.
  - Round 0 is valid the cycle after acceptance (latency 1).
- EXPAND:
  - key_ready_out=0; rk_valid_out=1; busy_out=1.
  - key_valid_in is ignored; no key is latched, no error is flagged.
- Advance: when rk_valid_out and rk_ready_in are both 1 at a rising edge.
  - If rk_round_out<10: rk_out <= next(rk_out) and rk_round_out increments.
  - If rk_round_out==10: go to IDLE; rk_valid_out=0 and key_ready_out=1 next cycle.
- Stall: rk_ready_in=0 holds rk_out and rk_round_out stable for any number of cycles.
- Round-key function, round r = rk_round_out+1:
  - t = SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- S-box: the FIPS-197 forward table, combinational.
- Minimum key-to-key spacing: 12 cycles (11 beats plus 1 IDLE cycle); back-to-back acceptance on the final-beat cycle is not permitted.
- resetn asserted mid-expansion: immediate return to reset values; the partial sequence is discarded.
- rk_out and rk_round_out never change while rk_valid_out=1 and rk_ready_in=0.
- No X on any output when resetn=1.

Optional Feature:
- Macro: AES_KEY_LAST_OUT_EN.
- When defined:
  - Adds outputs last_key_valid_out (1) and last_key_out (128).
  - On the round-10 advance, the round-10 key is captured and last_key_valid_out is set.
  - Both hold until the next key acceptance, which clears last_key_valid_out.
  - Reset values are 0.
  - The captured key is the decrypt start key.
- When undefined: the ports and registers do not exist; all other behaviour is identical.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready_in=1:
  - round 0 = key, one cycle after accept.
  - round 1 = a0fafe1788542cb123a339392a6c7605.
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - 11 consecutive valid beats, then key_ready_out=1.
- Key 5468617473206D79204B756E67204675:
  - round 1 = e232fcf191129188b159e4e6d679a293.
  - round 10 = 28fddef86da4244accc0a4fe3b316f26.
- Backpressure: rk_ready_in toggled randomly with the FIPS key -> identical 11-key sequence, outputs stable during every stall, no beats dropped or duplicated.
- key_valid_in=1 with a different key during EXPAND (round 4) -> ignored, sequence unchanged, key_ready_out=0 until after round 10.
- resetn pulsed low at round 5 -> rk_valid_out=0, key_ready_out=1 asynchronously; new key then expands from round 0 correctly.
- AES_KEY_LAST_OUT_EN defined, FIPS key -> last_key_out = d014f9a8c9ee2589e13f0cc8b6630ca6 with last_key_valid_out=1 after round-10 handshake; cleared on next key accept.
